// File: rtl/split_access_unit_pkg.sv
// Shared types and helpers for the split load/store access unit.
package split_access_unit_pkg;

  // Sequencing states: accept, first bus beat, optional second beat, response.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  // Widest beat the lane-mask helper can describe (1024-bit bus).
  localparam int MAX_NB = 128;

  // Contiguous low-order mask with n bits set (n = access size in bytes).
  function automatic logic [MAX_NB-1:0] mask(input logic [7:0] n);
    logic [MAX_NB-1:0] m;
    m = {MAX_NB{1'b0}};
    for (int i = 0; i < MAX_NB; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction

endpackage

// File: rtl/split_access_unit_split_plan.sv
// Combinational planning of one access: lane offset, whether it straddles a
// bus word, beat addresses, and the strobes / shifted store data of both beats.
module split_plan
  import split_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  localparam int NB        = DATA_WIDTH / 8,
  localparam int LOG2NB    = $clog2(NB)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [LOG2NB-1:0]     off,
  output logic                  split,
  output logic                  size_err,
  output logic [ADDR_WIDTH-1:0] base0,
  output logic [ADDR_WIDTH-1:0] base1,
  output logic [NB-1:0]         strobe0,
  output logic [NB-1:0]         strobe1,
  output logic [DATA_WIDTH-1:0] wdata0,
  output logic [DATA_WIDTH-1:0] wdata1
);

  logic [7:0]        n;
  logic [LOG2NB:0]   rsh;
  logic [NB-1:0]     m;

  // Derive the beat plan; the second-beat shifts use NB-off so that the bytes
  // spilling past the first word land at lane 0 of the next word.
  always_comb begin
    off      = addr[LOG2NB-1:0];
    n        = 8'd1 << size;
    split    = (int'(off) + int'(n)) > NB;
    size_err = int'(size) > LOG2NB;
    base0    = addr & ~ADDR_WIDTH'(NB - 1);
    base1    = base0 + ADDR_WIDTH'(NB);
    m        = NB'(mask(n));
    rsh      = (LOG2NB + 1)'(NB) - (LOG2NB + 1)'(off);
    strobe0  = m << off;
    strobe1  = m >> rsh;
    wdata0   = wdata << {off, 3'b000};
    wdata1   = wdata >> {rsh, 3'b000};
  end

endmodule

// File: rtl/split_access_unit.sv
// Load/store access unit: splits bus-word-straddling requests into two beats,
// merges read lanes and sign/zero-extends load results. All outputs registered.
module split_access_unit
  import split_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  localparam int NB        = DATA_WIDTH / 8,
  localparam int LOG2NB    = $clog2(NB)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_size,
  input  logic                  req_write,
  input  logic                  req_zext,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  dbus_valid,
  output logic [ADDR_WIDTH-1:0] dbus_addr,
  output logic [NB-1:0]         dbus_strobe,
  output logic [DATA_WIDTH-1:0] dbus_wdata,
  input  logic                  dbus_ok,
  input  logic [DATA_WIDTH-1:0] dbus_rdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err
);

  lsu_state_t state_r, next_state;

  logic [ADDR_WIDTH-1:0] addr_r;
  logic [2:0]            size_r;
  logic                  write_r;
  logic                  zext_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [DATA_WIDTH-1:0] merge_r, merge_d;

  logic [ADDR_WIDTH-1:0] p_addr;
  logic [2:0]            p_size;
  logic                  p_write;
  logic                  p_zext;
  logic [DATA_WIDTH-1:0] p_wdata;

  logic [LOG2NB-1:0]     p_off;
  logic [LOG2NB:0]       hi_sh;
  logic                  p_split;
  logic                  p_err;
  logic [ADDR_WIDTH-1:0] p_base0, p_base1;
  logic [NB-1:0]         p_strobe0, p_strobe1;
  logic [DATA_WIDTH-1:0] p_wdata0, p_wdata1;

  logic                  dbus_valid_d;
  logic [ADDR_WIDTH-1:0] dbus_addr_d;
  logic [NB-1:0]         dbus_strobe_d;
  logic [DATA_WIDTH-1:0] dbus_wdata_d;
  logic                  resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_d;
  logic                  resp_err_d;

  // Keep the low 2^sz bytes and fill the rest with zeros or the sign bit;
  // a full-width access passes through untouched.
  function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] d,
                                                   input logic [2:0] sz,
                                                   input logic zx);
    logic [DATA_WIDTH-1:0] r;
    int                    nbits;
    logic                  sgn;
    nbits = 8 << sz;
    sgn   = 1'b0;
    r     = d;
    if (int'(sz) >= LOG2NB) begin
      r = d;
    end else begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (i == nbits - 1) sgn = d[i];
        else                sgn = sgn;
      end
      for (int i = 0; i < DATA_WIDTH; i++) begin
        r[i] = (i < nbits) ? d[i] : (~zx & sgn);
      end
    end
    return r;
  endfunction

  assign req_ready = (state_r == ST_IDLE);

  // Plan from the live request while idle, from the captured request otherwise.
  always_comb begin
    if (state_r == ST_IDLE) begin
      p_addr  = req_addr;
      p_size  = req_size;
      p_write = req_write;
      p_zext  = req_zext;
      p_wdata = req_wdata;
    end else begin
      p_addr  = addr_r;
      p_size  = size_r;
      p_write = write_r;
      p_zext  = zext_r;
      p_wdata = wdata_r;
    end
  end

  split_plan #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_plan (
    .addr     (p_addr),
    .size     (p_size),
    .wdata    (p_wdata),
    .off      (p_off),
    .split    (p_split),
    .size_err (p_err),
    .base0    (p_base0),
    .base1    (p_base1),
    .strobe0  (p_strobe0),
    .strobe1  (p_strobe1),
    .wdata0   (p_wdata0),
    .wdata1   (p_wdata1)
  );

  assign hi_sh = (LOG2NB + 1)'(NB) - (LOG2NB + 1)'(p_off);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= next_state;
  end

  // Next-state decode.
  always_comb begin
    next_state = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) next_state = p_err ? ST_RESP : ST_BEAT0;
        else           next_state = ST_IDLE;
      end
      ST_BEAT0: begin
        if (dbus_ok) next_state = p_split ? ST_BEAT1 : ST_RESP;
        else         next_state = ST_BEAT0;
      end
      ST_BEAT1: begin
        if (dbus_ok) next_state = ST_RESP;
        else         next_state = ST_BEAT1;
      end
      ST_RESP: begin
        if (resp_ready) next_state = ST_IDLE;
        else            next_state = ST_RESP;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Next values of merge buffer and registered outputs, keyed on the state
  // being entered so every output is valid in the first cycle of its state.
  always_comb begin
    merge_d       = merge_r;
    dbus_valid_d  = 1'b0;
    dbus_addr_d   = {ADDR_WIDTH{1'b0}};
    dbus_strobe_d = {NB{1'b0}};
    dbus_wdata_d  = {DATA_WIDTH{1'b0}};
    resp_valid_d  = 1'b0;
    resp_data_d   = {DATA_WIDTH{1'b0}};
    resp_err_d    = 1'b0;

    case (state_r)
      ST_IDLE: merge_d = {DATA_WIDTH{1'b0}};
      ST_BEAT0: begin
        if (dbus_ok && !p_write) merge_d = dbus_rdata >> {p_off, 3'b000};
        else                     merge_d = merge_r;
      end
      ST_BEAT1: begin
        if (dbus_ok && !p_write) merge_d = merge_r | (dbus_rdata << {hi_sh, 3'b000});
        else                     merge_d = merge_r;
      end
      default: merge_d = merge_r;
    endcase

    case (next_state)
      ST_BEAT0: begin
        dbus_valid_d  = 1'b1;
        dbus_addr_d   = p_base0;
        dbus_strobe_d = p_write ? p_strobe0 : {NB{1'b0}};
        dbus_wdata_d  = p_wdata0;
      end
      ST_BEAT1: begin
        dbus_valid_d  = 1'b1;
        dbus_addr_d   = p_base1;
        dbus_strobe_d = p_write ? p_strobe1 : {NB{1'b0}};
        dbus_wdata_d  = p_wdata1;
      end
      ST_RESP: begin
        resp_valid_d = 1'b1;
        resp_err_d   = p_err;
        if (p_err || p_write) resp_data_d = {DATA_WIDTH{1'b0}};
        else                  resp_data_d = extend(merge_d, p_size, p_zext);
      end
      default: begin
        dbus_valid_d = 1'b0;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // Capture the request on acceptance; hold it for the rest of the access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_r  <= {ADDR_WIDTH{1'b0}};
      size_r  <= 3'd0;
      write_r <= 1'b0;
      zext_r  <= 1'b0;
      wdata_r <= {DATA_WIDTH{1'b0}};
    end else if (state_r == ST_IDLE && req_valid) begin
      addr_r  <= req_addr;
      size_r  <= req_size;
      write_r <= req_write;
      zext_r  <= req_zext;
      wdata_r <= req_wdata;
    end
  end

  // Merge buffer and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      merge_r     <= {DATA_WIDTH{1'b0}};
      dbus_valid  <= 1'b0;
      dbus_addr   <= {ADDR_WIDTH{1'b0}};
      dbus_strobe <= {NB{1'b0}};
      dbus_wdata  <= {DATA_WIDTH{1'b0}};
      resp_valid  <= 1'b0;
      resp_data   <= {DATA_WIDTH{1'b0}};
      resp_err    <= 1'b0;
    end else begin
      merge_r     <= merge_d;
      dbus_valid  <= dbus_valid_d;
      dbus_addr   <= dbus_addr_d;
      dbus_strobe <= dbus_strobe_d;
      dbus_wdata  <= dbus_wdata_d;
      resp_valid  <= resp_valid_d;
      resp_data   <= resp_data_d;
      resp_err    <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_split_access_unit.sv
// Self-checking bench for split_access_unit (64-bit bus, 64-bit address).
// A byte-level memory model predicts bus beats and load results.
module tb_split_access_unit;

  localparam int DW = 64;
  localparam int AW = 64;
  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [2:0]    req_size = '0;
  logic          req_write = 1'b0;
  logic          req_zext = 1'b0;
  logic [DW-1:0] req_wdata = '0;
  logic          dbus_valid;
  logic [AW-1:0] dbus_addr;
  logic [NB-1:0] dbus_strobe;
  logic [DW-1:0] dbus_wdata;
  logic          dbus_ok = 1'b0;
  logic [DW-1:0] dbus_rdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [DW-1:0] resp_data;
  logic          resp_err;

  int nchecks = 0;
  int nerrors = 0;

  logic [7:0]  mem [logic [63:0]];
  logic [63:0] cap_addr [2];
  logic [7:0]  cap_strb [2];
  logic [63:0] cap_wd   [2];

  split_access_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_write(req_write), .req_zext(req_zext), .req_wdata(req_wdata),
    .dbus_valid(dbus_valid), .dbus_addr(dbus_addr), .dbus_strobe(dbus_strobe),
    .dbus_wdata(dbus_wdata), .dbus_ok(dbus_ok), .dbus_rdata(dbus_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_get(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    else return a[7:0] ^ a[15:8] ^ a[63:56] ^ 8'h5A;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_dbus_valid", dbus_valid, 0);
    chk("rst_dbus_addr", dbus_addr, 0);
    chk("rst_dbus_strobe", dbus_strobe, 0);
    chk("rst_dbus_wdata", dbus_wdata, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_err", resp_err, 0);
  endtask

  // One complete access: drive request, serve beats, check against the model.
  task automatic run_op(input logic [63:0] a, input logic [2:0] sz, input logic wr,
                        input logic zx, input logic [63:0] wd, input int max_wait,
                        input int stall, output logic [63:0] obs_data, output logic obs_err);
    int n, exp_nb, exp_lat, beat, wl, c, b;
    bit err, done;
    logic [63:0] eaddr [2];
    logic [7:0]  estrb [2];
    logic [63:0] ewd [2];
    logic [63:0] raw, edata, ba, bm;
    n = 1 << sz;
    err = (sz > 3);
    eaddr[0] = a & ~64'h7;
    eaddr[1] = eaddr[0] + 64'd8;
    estrb[0] = 8'h00; estrb[1] = 8'h00;
    ewd[0] = 64'h0; ewd[1] = 64'h0;
    raw = 64'h0;
    exp_nb = err ? 0 : 1;
    if (!err) begin
      for (int k = 0; k < n; k++) begin
        ba = a + 64'(k);
        b = ((ba & ~64'h7) == eaddr[0]) ? 0 : 1;
        if (b == 1) exp_nb = 2;
        if (wr) begin
          estrb[b][ba[2:0]] = 1'b1;
          ewd[b][8*ba[2:0] +: 8] = wd[8*k +: 8];
        end
        raw[8*k +: 8] = mem_get(ba);
      end
    end
    if (err || wr) edata = 64'h0;
    else if (zx || n == 8) edata = raw;
    else if (((raw >> (8*n - 1)) & 64'd1) != 0) edata = raw | ~((64'd1 << (8*n)) - 64'd1);
    else edata = raw;
    exp_lat = (exp_nb == 2) ? 3 : 2;
    obs_data = 64'h0;
    obs_err = 1'b0;

    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_addr = a; req_size = sz; req_write = wr; req_zext = zx; req_wdata = wd;
    wl = $urandom_range(0, max_wait);
    beat = 0; done = 0; c = 0;
    while (!done && c < 100) begin
      @(negedge clk);
      c++;
      // Scramble request inputs: they must be ignored while busy.
      req_valid = 1'($urandom_range(0, 1));
      req_addr = {$urandom, $urandom}; req_size = 3'($urandom); req_write = 1'($urandom);
      req_zext = 1'($urandom); req_wdata = {$urandom, $urandom};
      dbus_ok = 1'b0;
      dbus_rdata = {$urandom, $urandom};
      chk("req_ready_busy", req_ready, 0);
      if (resp_valid) begin
        chk("beats", beat, exp_nb);
        chk("dbus_idle_resp", dbus_valid, 0);
        chk("resp_err", resp_err, err);
        chk("resp_data", resp_data, edata);
        if (max_wait == 0) begin
          if (err) chk("lat_err", c <= 2, 1);
          else     chk("latency", c, exp_lat);
        end
        obs_data = resp_data;
        obs_err = resp_err;
        resp_ready = (stall == 0);
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          chk("hold_valid", resp_valid, 1);
          chk("hold_data", resp_data, edata);
          chk("hold_err", resp_err, err);
          if (s == stall - 1) resp_ready = 1'b1;
        end
        req_valid = 1'b0;
        done = 1;
      end else if (dbus_valid) begin
        if (beat >= exp_nb) begin
          chk("extra_beat", beat, exp_nb);
        end else begin
          chk("beat_addr", dbus_addr, eaddr[beat]);
          chk("beat_strobe", dbus_strobe, estrb[beat]);
          if (wr) begin
            bm = 64'h0;
            for (int l = 0; l < 8; l++) if (estrb[beat][l]) bm[8*l +: 8] = 8'hFF;
            chk("beat_wdata", dbus_wdata & bm, ewd[beat] & bm);
          end
          if (wl == 0) begin
            dbus_ok = 1'b1;
            for (int l = 0; l < 8; l++) dbus_rdata[8*l +: 8] = mem_get(eaddr[beat] + 64'(l));
            cap_addr[beat] = dbus_addr;
            cap_strb[beat] = dbus_strobe;
            cap_wd[beat] = dbus_wdata;
            beat++;
            wl = $urandom_range(0, max_wait);
          end else begin
            wl--;
          end
        end
      end else begin
        chk("dbus_valid_busy", dbus_valid, 1);
      end
    end
    if (!done) begin
      chk("timeout", done, 1);
      req_valid = 1'b0;
      resp_ready = 1'b1;
    end
  endtask

  initial begin
    logic [63:0] d;
    logic        e;
    logic [63:0] ra;
    logic [2:0]  rs;

    // Reset state.
    #3;
    chk_reset_vals();
    @(negedge clk);
    reset = 1'b1;

    // LBU at 0x1003 from word 0x0011_2233_4455_6677.
    for (int i = 0; i < 8; i++) mem[64'h1000 + 64'(i)] = 8'h77 - 8'(8'h11 * i);
    run_op(64'h1003, 3'd0, 1'b0, 1'b1, 64'h0, 0, 0, d, e);
    chk("lbu_data", d, 64'h44);
    chk("lbu_addr", cap_addr[0], 64'h1000);
    chk("lbu_strobe", cap_strb[0], 8'h00);

    // Split SW 0xDEADBEEF at 0x1006.
    run_op(64'h1006, 3'd2, 1'b1, 1'b0, 64'hDEADBEEF, 0, 0, d, e);
    chk("sw_b0_addr", cap_addr[0], 64'h1000);
    chk("sw_b0_strobe", cap_strb[0], 8'hC0);
    chk("sw_b0_wdata", cap_wd[0], 64'hBEEF_0000_0000_0000);
    chk("sw_b1_addr", cap_addr[1], 64'h1008);
    chk("sw_b1_strobe", cap_strb[1], 8'h03);
    chk("sw_b1_wdata", cap_wd[1] & 64'hFFFF, 64'hDEAD);
    chk("sw_data", d, 64'h0);

    // Split LH / LHU at 0x1007.
    mem[64'h1007] = 8'h34;
    mem[64'h1008] = 8'h92;
    run_op(64'h1007, 3'd1, 1'b0, 1'b0, 64'h0, 0, 0, d, e);
    chk("lh_data", d, 64'hFFFF_FFFF_FFFF_9234);
    run_op(64'h1007, 3'd1, 1'b0, 1'b1, 64'h0, 1, 0, d, e);
    chk("lhu_data", d, 64'h9234);

    // LD at the top of the address space: second beat wraps to 0.
    run_op(64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0, 1'b0, 64'h0, 0, 0, d, e);
    chk("wrap_b1_addr", cap_addr[1], 64'h0);

    // Illegal size.
    run_op(64'h1000, 3'd4, 1'b0, 1'b0, 64'h0, 0, 0, d, e);
    chk("err_flag", e, 1);

    // Response held for 5 cycles of resp_ready low.
    run_op(64'h2003, 3'd1, 1'b0, 1'b0, 64'h0, 0, 5, d, e);

    // Reset while BEAT1 waits on dbus_ok.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 64'h2004; req_size = 3'd3; req_write = 1'b0; req_zext = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_b0_valid", dbus_valid, 1);
    dbus_ok = 1'b1;
    @(negedge clk);
    dbus_ok = 1'b0;
    chk("mid_b1_addr", dbus_addr, 64'h2008);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_reset_vals();
    @(negedge clk);
    reset = 1'b1;
    run_op(64'h2005, 3'd2, 1'b0, 1'b1, 64'h0, 0, 0, d, e);

    // Randomized accesses.
    for (int t = 0; t < 60; t++) begin
      ra = {$urandom, $urandom};
      if (t % 5 == 0) ra = 64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(0, 7));
      rs = 3'($urandom_range(0, 4));
      run_op(ra, rs, 1'($urandom), 1'($urandom), {$urandom, $urandom},
             $urandom_range(0, 2), $urandom_range(0, 2), d, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
